// File: rtl/lcd_tile_renderer_if.sv
// -----------------------------------------------------------------------------
// lcd_tile_renderer_if
// Tile write port of the LCD tile renderer (valid/ready handshake).
//   in_wr_valid  : requester has a tile write pending
//   out_wr_ready : renderer can accept a write this cycle
//   in_wr_tx     : tile column of the write
//   in_wr_ty     : tile row of the write
//   in_wr_color  : 4-bit colour index to store
// master = requester (game/demo logic), slave = renderer.
// -----------------------------------------------------------------------------
interface lcd_tile_renderer_if;
   logic       in_wr_valid;
   logic       out_wr_ready;
   logic [5:0] in_wr_tx;
   logic [5:0] in_wr_ty;
   logic [3:0] in_wr_color;

   modport master (
      output in_wr_valid,
      output in_wr_tx,
      output in_wr_ty,
      output in_wr_color,
      input  out_wr_ready
   );

   modport slave (
      input  in_wr_valid,
      input  in_wr_tx,
      input  in_wr_ty,
      input  in_wr_color,
      output out_wr_ready
   );
endinterface

// File: rtl/lcd_tile_renderer.sv
// -----------------------------------------------------------------------------
// lcd_tile_renderer
// Pixel-colour stage between the 480x272 LCD timing generator and the RGB pins.
// Holds a 60x34 map of 8x8 tiles (4-bit colour index each) and turns pixel
// coordinates into RGB565 through a 3-cycle pipeline. en/hsync/vsync are
// delayed by the same 3 cycles. After reset the tile map is cleared to 0,
// which takes one cycle per tile.
//
// Ports:
//   in_clk, in_rst          : pixel clock, synchronous active-high reset
//   in_en/in_hsync/in_vsync : timing generator controls
//   in_pixelx/in_pixely     : current pixel coordinate
//   wr_if (slave)           : valid/ready tile write port
//   out_en/out_hsync/out_vsync : controls delayed by 3 cycles
//   out_r/out_g/out_b       : RGB565 colour
//   out_busy                : tile map clear in progress
//
// Build option: define LCD_TILE_GRID_EN to draw a grey grid on the first
// row/column of every tile.
// -----------------------------------------------------------------------------
module lcd_tile_renderer #(
   parameter int H_TILES    = 60,
   parameter int V_TILES    = 34,
   parameter int TILE_SHIFT = 3
) (
   input  logic               in_clk,
   input  logic               in_rst,
   input  logic               in_en,
   input  logic               in_hsync,
   input  logic               in_vsync,
   input  logic [9:0]         in_pixelx,
   input  logic [9:0]         in_pixely,
   lcd_tile_renderer_if.slave wr_if,
   output logic               out_en,
   output logic               out_hsync,
   output logic               out_vsync,
   output logic [4:0]         out_r,
   output logic [5:0]         out_g,
   output logic [4:0]         out_b,
   output logic               out_busy
);

   localparam logic [9:0]  H_PIX      = 10'(H_TILES << TILE_SHIFT);
   localparam logic [9:0]  V_PIX      = 10'(V_TILES << TILE_SHIFT);
   localparam logic [5:0]  H_TILES_W  = 6'(H_TILES);
   localparam logic [5:0]  V_TILES_W  = 6'(V_TILES);
   localparam logic [10:0] LAST_ADDR  = 11'(H_TILES * V_TILES - 1);
   localparam int          SYNC_STAGES = 3;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   // Row-major tile address ty*60 + tx, built from shifts so no multiplier
   // is needed: ty*64 - ty*4 + tx.
   function automatic logic [10:0] tile_addr(input logic [6:0] tx, input logic [6:0] ty);
      logic [10:0] ty_ext;
      ty_ext = {4'b0, ty};
      return (ty_ext << 6) - (ty_ext << 2) + {4'b0, tx};
   endfunction

   // Bit 0/1/2 enable red/green/blue; bit 3 selects half intensity.
   function automatic logic [15:0] palette(input logic [3:0] idx);
      logic [4:0] rb_on;
      logic [5:0] g_on;
      rb_on = idx[3] ? 5'h0F : 5'h1F;
      g_on  = idx[3] ? 6'h1F : 6'h3F;
      return {idx[0] ? rb_on : 5'h00, idx[1] ? g_on : 6'h00, idx[2] ? rb_on : 5'h00};
   endfunction

   // ---------------------------------------------------------------- FSM
   state_t      r_state;
   state_t      w_state_next;
   logic [10:0] r_clr_addr;
   logic [10:0] w_clr_addr_next;
   logic        w_busy;
   logic        w_ready;
   logic        w_ram_we;
   logic [10:0] w_ram_waddr;
   logic [3:0]  w_ram_wdata;
   logic        w_wr_inrange;

   assign w_wr_inrange = (wr_if.in_wr_tx < H_TILES_W) && (wr_if.in_wr_ty < V_TILES_W);

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_next;
         r_clr_addr <= w_clr_addr_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_clr_addr_next = r_clr_addr;
      w_busy          = 1'b1;
      w_ready         = 1'b0;
      w_ram_we        = 1'b0;
      w_ram_waddr     = r_clr_addr;
      w_ram_wdata     = 4'h0;
      case (r_state)
         ST_CLEAR: begin
            w_ram_we        = 1'b1;
            w_clr_addr_next = r_clr_addr + 11'd1;
            if (r_clr_addr == LAST_ADDR) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_busy  = 1'b0;
            w_ready = 1'b1;
            // Out-of-range writes complete the handshake but never reach the RAM.
            w_ram_we    = wr_if.in_wr_valid && w_wr_inrange;
            w_ram_waddr = tile_addr({1'b0, wr_if.in_wr_tx}, {1'b0, wr_if.in_wr_ty});
            w_ram_wdata = wr_if.in_wr_color;
         end
         default: w_state_next = ST_CLEAR;
      endcase
   end

   assign out_busy           = w_busy;
   assign wr_if.out_wr_ready = w_ready;

   // ------------------------------------------------------ sync delay line
   // Bit 2 = en, bit 1 = hsync, bit 0 = vsync. Stage 1 en doubles as the
   // S2 copy of en used to gate the colour.
   logic [SYNC_STAGES-1:0][2:0] r_sync_dly;
   logic [SYNC_STAGES-1:0][2:0] w_sync_next;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign w_sync_next[gi] = {in_en, in_hsync, in_vsync};
         end else begin : g_rest
            assign w_sync_next[gi] = r_sync_dly[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_sync_dly <= '0;
      end else begin
         r_sync_dly <= w_sync_next;
      end
   end

   assign out_en    = r_sync_dly[SYNC_STAGES-1][2];
   assign out_hsync = r_sync_dly[SYNC_STAGES-1][1];
   assign out_vsync = r_sync_dly[SYNC_STAGES-1][0];

   // -------------------------------------------------------- S1: coordinates
   logic [6:0] r_s1_tx;
   logic [6:0] r_s1_ty;
   logic       r_s1_inrange;
   logic       r_s2_inrange;
`ifdef LCD_TILE_GRID_EN
   logic       r_s1_grid;
   logic       r_s2_grid;
`endif

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_s1_tx      <= '0;
         r_s1_ty      <= '0;
         r_s1_inrange <= 1'b0;
         r_s2_inrange <= 1'b0;
`ifdef LCD_TILE_GRID_EN
         r_s1_grid    <= 1'b0;
         r_s2_grid    <= 1'b0;
`endif
      end else begin
         r_s1_tx      <= 7'(in_pixelx >> TILE_SHIFT);
         r_s1_ty      <= 7'(in_pixely >> TILE_SHIFT);
         r_s1_inrange <= (in_pixelx < H_PIX) && (in_pixely < V_PIX);
         r_s2_inrange <= r_s1_inrange;
`ifdef LCD_TILE_GRID_EN
         r_s1_grid    <= (in_pixelx[TILE_SHIFT-1:0] == '0) || (in_pixely[TILE_SHIFT-1:0] == '0);
         r_s2_grid    <= r_s1_grid;
`endif
      end
   end

   // ------------------------------------------------------- S2: tile RAM
   // Read and write share one edge; a read of the address being written
   // returns the previous contents.
   logic [3:0]  r_ram [0:2047];
   logic [3:0]  r_s2_data;
   logic [10:0] w_rd_addr;

   assign w_rd_addr = tile_addr(r_s1_tx, r_s1_ty);

   always_ff @(posedge in_clk) begin
      if (w_ram_we && !in_rst) begin
         r_ram[w_ram_waddr] <= w_ram_wdata;
      end
      r_s2_data <= r_ram[w_rd_addr];
   end

   // -------------------------------------------------------- S3: palette
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         {out_r, out_g, out_b} <= '0;
      end else if (r_sync_dly[1][2] && r_s2_inrange && (r_state == ST_RUN)) begin
`ifdef LCD_TILE_GRID_EN
         if (r_s2_grid) begin
            {out_r, out_g, out_b} <= {5'h08, 6'h10, 5'h08};
         end else begin
            {out_r, out_g, out_b} <= palette(r_s2_data);
         end
`else
         {out_r, out_g, out_b} <= palette(r_s2_data);
`endif
      end else begin
         {out_r, out_g, out_b} <= '0;
      end
   end

endmodule

// File: tb/tb_lcd_tile_renderer.sv
// -----------------------------------------------------------------------------
// tb_lcd_tile_renderer
// Self-checking bench for lcd_tile_renderer: a tile-map reference model with a
// fixed 3-cycle output latency checks every cycle, a constant table checks
// palette/boundary cases, and hand sequences cover clear timing, collision
// and reset mid-frame. Honours LCD_TILE_GRID_EN when defined.
// -----------------------------------------------------------------------------
module tb_lcd_tile_renderer;

   logic       clk = 1'b0;
   logic       rst, en, hs, vs;
   logic [9:0] px, py;
   logic       out_en, out_hsync, out_vsync, out_busy;
   logic [4:0] out_r, out_b;
   logic [5:0] out_g;

   always #5 clk = ~clk;

   lcd_tile_renderer_if wr_bus();

   lcd_tile_renderer dut (
      .in_clk    (clk),
      .in_rst    (rst),
      .in_en     (en),
      .in_hsync  (hs),
      .in_vsync  (vs),
      .in_pixelx (px),
      .in_pixely (py),
      .wr_if     (wr_bus),
      .out_en    (out_en),
      .out_hsync (out_hsync),
      .out_vsync (out_vsync),
      .out_r     (out_r),
      .out_g     (out_g),
      .out_b     (out_b),
      .out_busy  (out_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Drive values applied by tick()
   logic       d_rst = 1'b0, d_en = 1'b0, d_hs = 1'b0, d_vs = 1'b0, d_wv = 1'b0;
   logic [9:0] d_px = '0, d_py = '0;
   logic [5:0] d_tx = '0, d_ty = '0;
   logic [3:0] d_col = '0;

   // ---------------------------------------------------------- reference model
   logic [3:0] tiles [0:33][0:59];
   int         clr_cnt = 0;

   typedef struct {
      logic        en, hs, vs;
      int          x, y;
      logic [15:0] rgb;
   } stg_t;

   stg_t        s1, s2;
   logic        exp_en, exp_hs, exp_vs, exp_busy;
   logic [15:0] exp_rgb;

   function automatic logic [15:0] ref_colour(int x, int y);
      int idx, r, g, b, full;
      if (x >= 480 || y >= 272) return 16'h0;
`ifdef LCD_TILE_GRID_EN
      if (x % 8 == 0 || y % 8 == 0) return {5'd8, 6'd16, 5'd8};
`endif
      idx  = int'(tiles[y / 8][x / 8]);
      full = (idx < 8) ? 1 : 0;
      r = (idx % 2 == 1)       ? (full == 1 ? 31 : 15) : 0;
      g = ((idx / 2) % 2 == 1) ? (full == 1 ? 63 : 31) : 0;
      b = ((idx / 4) % 2 == 1) ? (full == 1 ? 31 : 15) : 0;
      return {5'(r), 6'(g), 5'(b)};
   endfunction

   // Advance the model across one rising edge with the current drive values.
   task automatic model_edge();
      logic running;
      running = (clr_cnt == 0);
      if (d_rst) begin
         exp_en = 0; exp_hs = 0; exp_vs = 0; exp_rgb = '0;
         s1 = '{en: 0, hs: 0, vs: 0, x: 0, y: 0, rgb: 16'h0};
         s2 = s1;
         clr_cnt = 2040;
         for (int y = 0; y < 34; y++)
            for (int x = 0; x < 60; x++) tiles[y][x] = 4'h0;
      end else begin
         exp_en  = s2.en;
         exp_hs  = s2.hs;
         exp_vs  = s2.vs;
         exp_rgb = (s2.en && running) ? s2.rgb : 16'h0;
         s2      = s1;
         s2.rgb  = ref_colour(s1.x, s1.y);   // sees tiles before this edge's write
         s1      = '{en: d_en, hs: d_hs, vs: d_vs, x: int'(d_px), y: int'(d_py), rgb: 16'h0};
         if (running && d_wv && d_tx < 6'd60 && d_ty < 6'd34)
            tiles[d_ty][d_tx] = d_col;
         if (clr_cnt > 0) clr_cnt--;
      end
      exp_busy = (clr_cnt > 0);
   endtask

   // One clock: drive at the falling edge, compare after the next falling edge.
   task automatic tick();
      logic [21:0] got, want;
      rst = d_rst; en = d_en; hs = d_hs; vs = d_vs; px = d_px; py = d_py;
      wr_bus.in_wr_valid = d_wv;
      wr_bus.in_wr_tx    = d_tx;
      wr_bus.in_wr_ty    = d_ty;
      wr_bus.in_wr_color = d_col;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      got  = {out_en, out_hsync, out_vsync, out_r, out_g, out_b, out_busy, wr_bus.out_wr_ready};
      want = {exp_en, exp_hs, exp_vs, exp_rgb, exp_busy, ~exp_busy};
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL scoreboard t=%0t en/hs/vs/rgb/busy/rdy got %b_%h_%b%b want %b_%h_%b%b",
                  $time, got[21:19], got[18:3], got[1], got[0],
                  want[21:19], want[18:3], want[1], want[0]);
      end
   endtask

   // Reset for one cycle (controls left as set by the caller), check black
   // output straight after, then count busy cycles.
   task automatic reset_and_count(input string tag);
      int n;
      d_rst = 1'b1;
      tick();
      d_rst = 1'b0;
      d_en  = 1'b0;
      n_tests++;
      if ({out_r, out_g, out_b, out_en} !== 17'h0 || out_busy !== 1'b1 || wr_bus.out_wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_after_reset rgb=%h en=%b busy=%b rdy=%b want 0000 0 1 0",
                  tag, {out_r, out_g, out_b}, out_en, out_busy, wr_bus.out_wr_ready);
      end
      n = 0;
      while (out_busy === 1'b1 && n < 5000) begin
         n++;
         tick();
      end
      n_tests++;
      if (n != 2040) begin
         n_fail++;
         $display("FAIL %s_clear_len busy cycles got %0d want 2040", tag, n);
      end
      $display("[TB] %s: busy for %0d cycles", tag, n);
   endtask

   // Show one pixel and return the colour 3 cycles later.
   task automatic read_pixel(input int x, input int y, output logic [15:0] rgb);
      d_wv = 1'b0;
      d_en = 1'b1; d_px = 10'(x); d_py = 10'(y);
      tick();
      d_en = 1'b0;
      tick();
      tick();
      rgb = {out_r, out_g, out_b};
   endtask

   task automatic check_rgb(input string name, input logic [15:0] got, input logic [15:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s rgb got %h want %h", name, got, want);
      end
   endtask

   // ------------------------------------------------------------ vector table
   typedef struct {
      logic [5:0]  tx, ty;
      logic [3:0]  col;
      int          x, y;
      logic [15:0] rgb;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(int tx, int ty, int col, int x, int y,
                                   logic [4:0] r, logic [5:0] g, logic [4:0] b);
      vecs.push_back('{tx: 6'(tx), ty: 6'(ty), col: 4'(col), x: x, y: y, rgb: {r, g, b}});
   endfunction

   initial begin
      logic [15:0] rgb;

      // tile (5,2) red, scan inside and just outside
      add_vec(5, 2, 1, 41, 17, 5'h1F, 6'h00, 5'h00);
      add_vec(5, 2, 1, 47, 23, 5'h1F, 6'h00, 5'h00);
      add_vec(5, 2, 1, 49, 17, 5'h00, 6'h00, 5'h00);
      // palette sweep over row 0
      add_vec( 0, 0,  0,   3, 3, 5'h00, 6'h00, 5'h00);
      add_vec( 1, 0,  1,  11, 3, 5'h1F, 6'h00, 5'h00);
      add_vec( 2, 0,  2,  19, 3, 5'h00, 6'h3F, 5'h00);
      add_vec( 3, 0,  3,  27, 3, 5'h1F, 6'h3F, 5'h00);
      add_vec( 4, 0,  4,  35, 3, 5'h00, 6'h00, 5'h1F);
      add_vec( 5, 0,  5,  43, 3, 5'h1F, 6'h00, 5'h1F);
      add_vec( 6, 0,  6,  51, 3, 5'h00, 6'h3F, 5'h1F);
      add_vec( 7, 0,  7,  59, 3, 5'h1F, 6'h3F, 5'h1F);
      add_vec( 8, 0,  8,  67, 3, 5'h00, 6'h00, 5'h00);
      add_vec( 9, 0,  9,  75, 3, 5'h0F, 6'h00, 5'h00);
      add_vec(10, 0, 10,  83, 3, 5'h00, 6'h1F, 5'h00);
      add_vec(11, 0, 11,  91, 3, 5'h0F, 6'h1F, 5'h00);
      add_vec(12, 0, 12,  99, 3, 5'h00, 6'h00, 5'h0F);
      add_vec(13, 0, 13, 107, 3, 5'h0F, 6'h00, 5'h0F);
      add_vec(14, 0, 14, 115, 3, 5'h00, 6'h1F, 5'h0F);
      add_vec(15, 0, 15, 123, 3, 5'h0F, 6'h1F, 5'h0F);
      // boundary tile and a dropped out-of-range write (would alias tile (0,1))
      add_vec(59, 33, 2, 479, 271, 5'h00, 6'h3F, 5'h00);
      add_vec(60,  0, 7,   1,   9, 5'h00, 6'h00, 5'h00);
      // grid corner: (8,9) lies on a grid line, (9,9) does not
`ifdef LCD_TILE_GRID_EN
      add_vec(1, 1, 1, 8, 9, 5'h08, 6'h10, 5'h08);
`else
      add_vec(1, 1, 1, 8, 9, 5'h1F, 6'h00, 5'h00);
`endif
      add_vec(1, 1, 1, 9, 9, 5'h1F, 6'h00, 5'h00);

      // ---- reset clear, with a write held pending through the clear
      d_wv = 1'b1; d_tx = 6'd3; d_ty = 6'd3; d_col = 4'h5;
      reset_and_count("initial");
      tick();                      // first RUN cycle accepts the held write
      d_wv = 1'b0;
      read_pixel(27, 27, rgb);
      check_rgb("held_write", rgb, {5'h1F, 6'h00, 5'h1F});

      // ---- random scan of the freshly cleared map
      for (int i = 0; i < 300; i++) begin
         d_en = 1'b1;
         d_px = 10'($urandom_range(0, 479));
         d_py = 10'($urandom_range(0, 271));
         d_hs = 1'($urandom_range(0, 1));
         d_vs = 1'($urandom_range(0, 1));
         tick();
      end
      d_en = 1'b0; d_hs = 1'b0; d_vs = 1'b0;

      // ---- table vectors: write one tile, read one pixel
      foreach (vecs[i]) begin
         d_wv = 1'b1; d_tx = vecs[i].tx; d_ty = vecs[i].ty; d_col = vecs[i].col;
         tick();
         read_pixel(vecs[i].x, vecs[i].y, rgb);
         $display("[TB] vec %0d tile(%0d,%0d)=%0h pix(%0d,%0d) rgb %h", i,
                  vecs[i].tx, vecs[i].ty, vecs[i].col, vecs[i].x, vecs[i].y, rgb);
         check_rgb($sformatf("vec%0d", i), rgb, vecs[i].rgb);
      end

      // ---- back-to-back scan of tile (5,2) and its right neighbour column
      for (int y = 16; y < 24; y++) begin
         for (int x = 40; x < 49; x++) begin
            d_en = 1'b1; d_px = 10'(x); d_py = 10'(y);
            tick();
         end
      end
      d_en = 1'b0;

      // ---- collision: write tile (0,0)=3 while S1 holds a tile (0,0) pixel
      d_en = 1'b1; d_px = 10'd1; d_py = 10'd1;
      tick();
      d_px = 10'd2; d_wv = 1'b1; d_tx = 6'd0; d_ty = 6'd0; d_col = 4'h3;
      tick();
      d_wv = 1'b0; d_en = 1'b0;
      tick();
      check_rgb("collision_old", {out_r, out_g, out_b}, 16'h0000);
      tick();
      check_rgb("collision_new", {out_r, out_g, out_b}, {5'h1F, 6'h3F, 5'h00});
      $display("[TB] collision sequence done");

      // ---- randomized traffic: writes (some out of range) and pixels
      for (int i = 0; i < 2500; i++) begin
         d_en  = ($urandom_range(0, 3) != 0);
         d_px  = 10'($urandom_range(0, 511));
         d_py  = 10'($urandom_range(0, 287));
         d_hs  = 1'($urandom_range(0, 1));
         d_vs  = 1'($urandom_range(0, 1));
         d_wv  = ($urandom_range(0, 2) == 0);
         d_tx  = 6'($urandom_range(0, 63));
         d_ty  = 6'($urandom_range(0, 40));
         d_col = 4'($urandom_range(0, 15));
         tick();
      end
      d_wv = 1'b0;
      $display("[TB] random traffic done");

      // ---- reset mid-frame while streaming a red tile
      d_en = 1'b1; d_px = 10'd41; d_py = 10'd17;
      d_wv = 1'b1; d_tx = 6'd5; d_ty = 6'd2; d_col = 4'h1;
      tick();
      d_wv = 1'b0;
      tick(); tick(); tick();
      check_rgb("pre_reset_red", {out_r, out_g, out_b}, {5'h1F, 6'h00, 5'h00});
      reset_and_count("midframe");

      // ---- map is black again
      for (int i = 0; i < 200; i++) begin
         d_en = 1'b1;
         d_px = 10'($urandom_range(0, 479));
         d_py = 10'($urandom_range(0, 271));
         tick();
      end
      d_en = 1'b0;
      read_pixel(41, 17, rgb);
      check_rgb("post_reset_black", rgb, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
